// File: rtl/multisim_pull_arbiter.sv
// Round-robin arbiter merging NUM_CHANNELS valid/ready pull streams into one registered,
// channel-tagged output stream, with a per-grant burst limit.
module multisim_pull_arbiter #(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned MAX_BURST    = 8,
    parameter int unsigned ID_WIDTH     = $clog2(NUM_CHANNELS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CHANNELS-1:0] in_vld,
    output logic [NUM_CHANNELS-1:0] in_rdy,
    input  logic [DATA_WIDTH-1:0]   in_data [NUM_CHANNELS],
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [ID_WIDTH-1:0]     out_id
);
    localparam int unsigned CntWidth = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {Idle, Locked} state_e;

    state_e              state;
    logic [ID_WIDTH-1:0] grant;
    logic [ID_WIDTH-1:0] rr_ptr;
    logic [CntWidth-1:0] burst_cnt;

    logic                load;
    logic                found;
    logic                take;
    logic                at_limit;
    logic [ID_WIDTH-1:0] winner;
    logic [ID_WIDTH-1:0] cand;
    logic [ID_WIDTH-1:0] src;
    logic [CntWidth-1:0] cnt_inc;
    int unsigned         idx;

    // Modulo increment so non-power-of-2 channel counts wrap correctly.
    function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] i);
        if (32'(i) == NUM_CHANNELS - 1) return '0;
        return i + ID_WIDTH'(1);
    endfunction

    assign load     = !out_vld || out_rdy;
    assign cnt_inc  = burst_cnt + CntWidth'(1);
    assign at_limit = (cnt_inc == CntWidth'(MAX_BURST));

    // Cyclic first-valid search starting at rr_ptr.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        cand   = '0;
        for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
            cand = ID_WIDTH'(idx);
            if (!found && in_vld[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        in_rdy = '0;
        src    = grant;
        take   = 1'b0;
        if (state == Idle) begin
            src  = winner;
            take = found && load;
            if (take) in_rdy[winner] = 1'b1;
        end else begin
            in_rdy[grant] = load;
            take          = load && in_vld[grant];
        end
        if (!rst_n) in_rdy = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= Idle;
            grant     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            out_vld   <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else begin
            if (take) begin
                out_vld  <= 1'b1;
                out_data <= in_data[src];
                out_id   <= src;
            end else if (load) begin
                out_vld  <= 1'b0;
            end

            case (state)
                Idle: begin
                    if (take) begin
                        grant     <= winner;
                        burst_cnt <= CntWidth'(1);
                        if (MAX_BURST > 1) state <= Locked;
                        else               rr_ptr <= wrap_inc(winner);
                    end
                end
                Locked: begin
                    if (take) begin
                        burst_cnt <= cnt_inc;
                        if (at_limit) begin
                            state  <= Idle;
                            rr_ptr <= wrap_inc(grant);
                        end
                    end else if (load) begin
                        // Granted channel went idle: release it.
                        state  <= Idle;
                        rr_ptr <= wrap_inc(grant);
                    end
                end
                default: state <= Idle;
            endcase
        end
    end

endmodule

// File: tb/tb_multisim_pull_arbiter.sv
// Self-checking bench for multisim_pull_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_multisim_pull_arbiter;

    localparam int MB = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  in_vld = '0;
    logic [3:0]  in_rdy;
    logic [63:0] in_data [4];
    logic        out_vld;
    logic        out_rdy = 1'b0;
    logic [63:0] out_data;
    logic [1:0]  out_id;

    logic [3:0]  b_vld = '0;
    logic [3:0]  b_rdy;
    logic [15:0] b_data [4];
    logic        b_out_vld;
    logic        b_out_rdy = 1'b0;
    logic [15:0] b_out_data;
    logic [1:0]  b_out_id;

    int checks = 0;
    int failures = 0;

    // Reference model: owner < 0 means no channel holds the output.
    int          m_owner;
    int          m_taken;
    int          m_start;
    logic        m_vld;
    logic [63:0] m_data;
    logic [1:0]  m_id;

    always #5 clk = ~clk;

    multisim_pull_arbiter #(
        .NUM_CHANNELS(4), .DATA_WIDTH(64), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_id(out_id)
    );

    multisim_pull_arbiter #(
        .NUM_CHANNELS(4), .DATA_WIDTH(16), .MAX_BURST(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .in_vld(b_vld), .in_rdy(b_rdy), .in_data(b_data),
        .out_vld(b_out_vld), .out_rdy(b_out_rdy), .out_data(b_out_data), .out_id(b_out_id)
    );

    function automatic int m_pick();
        int c;
        if (m_owner >= 0) return in_vld[m_owner[1:0]] ? m_owner : -1;
        for (int k = 0; k < 4; k++) begin
            c = (m_start + k) % 4;
            if (in_vld[c[1:0]]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_rdy();
        int p;
        if (m_vld && !out_rdy) return 4'b0000;
        if (m_owner >= 0) return 4'b0001 << m_owner;
        p = m_pick();
        if (p >= 0) return 4'b0001 << p;
        return 4'b0000;
    endfunction

    task automatic m_edge();
        int p;
        if (m_vld && !out_rdy) return;
        p = m_pick();
        if (p >= 0) begin
            m_vld  = 1'b1;
            m_data = in_data[p[1:0]];
            m_id   = p[1:0];
            if (m_owner < 0) begin
                m_owner = p;
                m_taken = 1;
            end else begin
                m_taken++;
            end
            if (m_taken == MB) begin
                m_start = (m_owner + 1) % 4;
                m_owner = -1;
            end
        end else begin
            m_vld = 1'b0;
            if (m_owner >= 0) begin
                m_start = (m_owner + 1) % 4;
                m_owner = -1;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_vld = '0;
        out_rdy = 1'b0;
        b_vld = '0;
        b_out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_owner = -1;
        m_taken = 0;
        m_start = 0;
        m_vld = 1'b0;
        m_data = '0;
        m_id = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_vld = 4'b1111;
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_rdy !== 4'b0000) begin
            failures++;
            $display("FAIL reset_rdy got=%b exp=0000", in_rdy);
        end
        checks++;
        if (out_vld !== 1'b0 || out_data !== 64'd0 || out_id !== 2'd0) begin
            failures++;
            $display("FAIL reset_out got vld=%b data=%h id=%0d exp 0/0/0", out_vld, out_data, out_id);
        end
    endtask

    task automatic test_single_channel();
        do_reset();
        out_rdy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_vld = 4'b0100;
            in_data[2] = 64'(100 + k);
            #1;
            checks++;
            if (in_rdy !== 4'b0100) begin
                failures++;
                $display("FAIL single_rdy beat=%0d got=%b exp=0100", k, in_rdy);
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_vld !== 1'b1 || out_id !== 2'd2 || out_data !== 64'(100 + k)) begin
                failures++;
                $display("FAIL single_out beat=%0d got vld=%b id=%0d data=%0d exp 1/2/%0d",
                         k, out_vld, out_id, out_data, 100 + k);
            end
        end
    endtask

    task automatic test_fairness();
        logic [63:0] sent [4];
        int exp_id;
        do_reset();
        out_rdy = 1'b1;
        in_vld = 4'b1111;
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 4; i++) begin
                sent[i] = {$urandom, $urandom};
                in_data[i] = sent[i];
            end
            exp_id = (k / 8) % 4;
            @(posedge clk);
            #1;
            checks++;
            if (out_vld !== 1'b1 || out_id !== exp_id[1:0] || out_data !== sent[exp_id]) begin
                failures++;
                $display("FAIL fair beat=%0d got vld=%b id=%0d data=%h exp 1/%0d/%h",
                         k, out_vld, out_id, out_data, exp_id, sent[exp_id]);
            end
        end
    endtask

    task automatic test_early_release();
        int          exp_ids [5] = '{1, 1, 1, -1, 3};
        logic [63:0] d3;
        do_reset();
        out_rdy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_vld = (c < 3) ? 4'b1010 : 4'b1000;
            for (int i = 0; i < 4; i++) in_data[i] = {$urandom, $urandom};
            d3 = in_data[3];
            @(posedge clk);
            #1;
            checks++;
            if (exp_ids[c] < 0) begin
                if (out_vld !== 1'b0) begin
                    failures++;
                    $display("FAIL release_bubble cyc=%0d got vld=%b exp 0", c, out_vld);
                end
            end else if (out_vld !== 1'b1 || 32'(out_id) != exp_ids[c]
                         || (c == 4 && out_data !== d3)) begin
                failures++;
                $display("FAIL release_id cyc=%0d got vld=%b id=%0d exp 1/%0d",
                         c, out_vld, out_id, exp_ids[c]);
            end
        end
    endtask

    task automatic test_backpressure();
        int          ids [$];
        logic [63:0] held;
        int          exp_id;
        do_reset();
        in_vld = 4'b0011;
        held = '0;
        for (int c = 0; c < 21; c++) begin
            out_rdy = !(c >= 3 && c < 8);
            for (int i = 0; i < 4; i++) in_data[i] = {$urandom, $urandom};
            if (c == 3) held = out_data;
            #1;
            if (!out_rdy) begin
                checks++;
                if (in_rdy !== 4'b0000 || out_vld !== 1'b1 || out_data !== held
                    || out_id !== 2'd0) begin
                    failures++;
                    $display("FAIL stall cyc=%0d got rdy=%b vld=%b id=%0d data=%h exp 0000/1/0/%h",
                             c, in_rdy, out_vld, out_id, out_data, held);
                end
            end
            @(posedge clk);
            #1;
            if (out_rdy) ids.push_back(int'(out_id));
        end
        for (int k = 0; k < ids.size(); k++) begin
            exp_id = (k / 8) % 2;
            checks++;
            if (ids[k] != exp_id) begin
                failures++;
                $display("FAIL bp_seq beat=%0d got id=%0d exp %0d", k, ids[k], exp_id);
            end
        end
    endtask

    task automatic test_burst_one();
        logic [3:0] exp_r;
        logic [1:0] exp_id;
        do_reset();
        b_vld = 4'b1001;
        b_out_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) b_data[i] = 16'($urandom);
            exp_id = (k % 2 == 0) ? 2'd0 : 2'd3;
            exp_r = 4'b0001 << exp_id;
            #1;
            checks++;
            if (b_rdy !== exp_r) begin
                failures++;
                $display("FAIL mb1_rdy beat=%0d got=%b exp=%b", k, b_rdy, exp_r);
            end
            @(posedge clk);
            #1;
            checks++;
            if (b_out_vld !== 1'b1 || b_out_id !== exp_id || b_out_data !== b_data[exp_id]) begin
                failures++;
                $display("FAIL mb1_out beat=%0d got vld=%b id=%0d exp 1/%0d",
                         k, b_out_vld, b_out_id, exp_id);
            end
        end
        b_vld = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_rdy = 1'b1;
        in_vld = 4'b0100;
        for (int i = 0; i < 4; i++) in_data[i] = {$urandom, $urandom};
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (out_vld !== 1'b1 || out_id !== 2'd2) begin
            failures++;
            $display("FAIL rstmid_pre got vld=%b id=%0d exp 1/2", out_vld, out_id);
        end
        rst_n = 1'b0;
        in_vld = 4'b1111;
        #1;
        checks++;
        if (out_vld !== 1'b0 || out_id !== 2'd0 || in_rdy !== 4'b0000) begin
            failures++;
            $display("FAIL rstmid_async got vld=%b id=%0d rdy=%b exp 0/0/0000",
                     out_vld, out_id, in_rdy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_vld = 4'b1110;
        #1;
        checks++;
        if (in_rdy !== 4'b0010) begin
            failures++;
            $display("FAIL rstmid_rdy got=%b exp=0010", in_rdy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_vld !== 1'b1 || out_id !== 2'd1) begin
            failures++;
            $display("FAIL rstmid_first got vld=%b id=%0d exp 1/1", out_vld, out_id);
        end
    endtask

    task automatic test_random();
        logic [3:0] exp_r;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            in_vld = 4'($urandom);
            out_rdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) in_data[i] = {$urandom, $urandom};
            #1;
            exp_r = m_rdy();
            checks++;
            if (in_rdy !== exp_r) begin
                failures++;
                $display("FAIL rand_rdy cyc=%0d got=%b exp=%b", c, in_rdy, exp_r);
            end
            checks++;
            if (out_vld !== m_vld || (m_vld && (out_id !== m_id || out_data !== m_data))) begin
                failures++;
                $display("FAIL rand_out cyc=%0d got vld=%b id=%0d data=%h exp %b/%0d/%h",
                         c, out_vld, out_id, out_data, m_vld, m_id, m_data);
            end
            @(posedge clk);
            m_edge();
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            in_data[i] = '0;
            b_data[i] = '0;
        end
        test_reset();
        test_single_channel();
        test_fairness();
        test_early_release();
        test_backpressure();
        test_burst_one();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multisim_pull_arbiter.md
# multisim_pull_arbiter

Round-robin arbiter that merges `NUM_CHANNELS` valid/ready pull streams into one registered output stream tagged with the source channel index. It sits downstream of several `multisim` pull servers and lets them share a single consumer, such as a decoder or a memory-write port. A per-grant burst limit bounds how long one server can hold the output. Accepted beats are never dropped, reordered or duplicated.

## Interface
Parameters:
- `NUM_CHANNELS`, default 4: number of input streams; minimum 2.
- `DATA_WIDTH`, default 64: payload width per beat.
- `MAX_BURST`, default 8: maximum consecutive beats per grant; minimum 1.
- `ID_WIDTH`, default `$clog2(NUM_CHANNELS)`: width of `out_id`.

Ports:
- `clk`  input  1  clock; all state updates on its rising edge.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `in_vld`  input  `NUM_CHANNELS`  per-channel data valid.
- `in_rdy`  output  `NUM_CHANNELS`  per-channel ready (combinational).
- `in_data`  input  `NUM_CHANNELS` x `DATA_WIDTH`  per-channel payload (unpacked array).
- `out_vld`  output  1  output beat valid (registered).
- `out_rdy`  input  1  consumer ready.
- `out_data`  output  `DATA_WIDTH`  output payload (registered).
- `out_id`  output  `ID_WIDTH`  index of the source channel of the current beat (registered).

## Operation
- Transfer rule: a beat moves on any port when valid and ready are both high at a rising edge.
- Load enable: `load = !out_vld || out_rdy`. This gives a single-entry output register.
- State: `state`, `grant` (`ID_WIDTH` bits), `rr_ptr` (`ID_WIDTH` bits), `burst_cnt` (`$clog2(MAX_BURST+1)` bits).
- FSM states are `IDLE` and `LOCKED`.
- In IDLE, the winner is the first channel `i` with `in_vld[i]` high, searching cyclically from `rr_ptr` up to `NUM_CHANNELS-1` and then wrapping to 0.
  - If a winner exists and `load` is high: `in_rdy[winner]=1`, the beat is captured, `grant<=winner`, `burst_cnt<=1`.
  - Next state is LOCKED if `MAX_BURST>1`. Otherwise it stays IDLE with `rr_ptr<=winner+1`.
  - If no winner exists or `load` is low: no transfer, state unchanged.
- In LOCKED, only `in_rdy[grant]` can be high. It equals `load`.
  - If `in_vld[grant]` and `load` are high: the beat is captured and `burst_cnt` increments.
  - If the new count equals `MAX_BURST`: go to IDLE with `rr_ptr<=grant+1`.
  - If `load` is high and `in_vld[grant]` is low: no transfer, go to IDLE with `rr_ptr<=grant+1`. The channel is released.
  - If `load` is low: hold the grant. The stalled cycle is not counted.
- Capture means `out_vld<=1`, `out_data<=in_data[src]`, `out_id<=src`.
- If `load` is high and nothing is captured, `out_vld<=0`. `out_data` and `out_id` hold their previous values.
- Pointer wrap-around: `grant+1` wraps from `NUM_CHANNELS-1` to 0. The increment is computed modulo `NUM_CHANNELS`, which also covers non-power-of-2 counts.
- At most one `in_rdy` bit is high in any cycle.
- `in_rdy` never depends on any `in_vld` other than those used for winner selection in IDLE.

## Timing
- Reset values: `out_vld=0`, `out_data=0`, `out_id=0`, `state=IDLE`, `grant=0`, `rr_ptr=0`, `burst_cnt=0`. `in_rdy` is all-zero while `rst_n` is low.
- Reset mid-operation: any beat held in the output register is discarded. Arbitration restarts at channel 0.
- Latency: an input beat accepted at edge N appears on `out_*` right after edge N.
- Throughput: one beat per cycle within a burst, with `out_rdy` held high.
- Burst-end rotation costs no cycle. The next edge is evaluated in IDLE and can transfer.
- Release because the granted channel dropped valid costs exactly one idle load cycle.
- Output stall with `out_rdy` low: `out_vld`, `out_data` and `out_id` stay stable and all `in_rdy` bits are 0.
- Simultaneous output drain and refill in the same edge is supported with no bubble.
- Combinational paths: `out_rdy` to `in_rdy`, and `in_vld` to `in_rdy` (IDLE only). There is no path from input to output.

## Test plan
- Single channel: ch2 streams 20 beats, `out_rdy=1`, `MAX_BURST=8`. Expect 20 beats in order, `out_id=2`, with no bubbles (ch2 re-wins each rotation).
- Fairness: all 4 channels always valid, `MAX_BURST=8`. Expect `out_id` sequence 0×8, 1×8, 2×8, 3×8, then 0×8 again, with no idle cycles.
- Early release: ch1 sends 3 beats then drops valid while ch3 is valid. Expect ids 1,1,1, then one cycle `out_vld=0`, then 3.
- Backpressure: `out_rdy=0` for 5 cycles mid-burst. Expect the beat to stay stable, `in_rdy=0`, and the burst to resume with its count unchanged and no loss or duplication.
- `MAX_BURST=1`, channels 0 and 3 valid. Expect alternating ids 0,3,0,3, with the pointer wrapping past 3 to 0.
- Reset pulse while `out_vld=1` and LOCKED on ch2. Expect `out_vld=0` immediately, `out_id=0`, and the first post-reset winner to be the lowest-indexed valid channel.
